// File: rtl/cpu_bus_lane_bridge.sv
// Serialises CPU bus requests onto a narrow pin lane (LSB lane first) and deserialises read data.
// Optional lane parity (pin_par, pin_par_in, cpu_perr) is enabled by defining BUS_LANE_PARITY_EN.
module cpu_bus_lane_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic [LANE_W-1:0] pin_out,
    output logic [LANE_W-1:0] pin_oe,
    input  logic [LANE_W-1:0] pin_in,
    input  logic              pin_rdy,
    output logic              pin_frame,
    output logic              pin_sync,
    output logic              pin_we,
    output logic [2:0]        dbg_state
`ifdef BUS_LANE_PARITY_EN
    ,
    output logic              pin_par,
    input  logic              pin_par_in,
    output logic              cpu_perr
`endif
);

    localparam int NA   = ADDR_W / LANE_W;
    localparam int ND   = DATA_W / LANE_W;
    localparam int MAXB = (NA > ND) ? NA : ND;
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam logic [BW-1:0] LAST_A = BW'(NA - 1);
    localparam logic [BW-1:0] LAST_D = BW'(ND - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_TURN  = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                perr_q, perr_d;

    // Handshakes: cpu_req is taken only in IDLE (one cycle of req is enough); a lane beat
    // completes on a rising edge where the lane is in a beat state and pin_rdy=1, else it holds.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
        pin_out   = '0;
        pin_oe    = '0;
        pin_frame = 1'b0;
        cpu_ack   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    beat_d  = '0;
                    perr_d  = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                pin_out   = addr_q[int'(beat_q)*LANE_W +: LANE_W];
                pin_oe    = '1;
                pin_frame = 1'b1;
                if (pin_rdy) begin
                    if (beat_q == LAST_A) begin
                        beat_d  = '0;
                        state_d = we_q ? S_WDATA : S_TURN;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_WDATA: begin
                pin_out   = wdata_q[int'(beat_q)*LANE_W +: LANE_W];
                pin_oe    = '1;
                pin_frame = 1'b1;
                if (pin_rdy) begin
                    if (beat_q == LAST_D) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_TURN: begin
                // Bus turnaround: nobody drives, pin_rdy deliberately ignored.
                pin_frame = 1'b1;
                state_d   = S_RDATA;
            end
            S_RDATA: begin
                pin_frame = 1'b1;
                if (pin_rdy) begin
                    shift_d[int'(beat_q)*LANE_W +: LANE_W] = pin_in;
`ifdef BUS_LANE_PARITY_EN
                    if (pin_par_in != ^pin_in) perr_d = 1'b1;
`endif
                    if (beat_q == LAST_D) begin
                        rdata_d = shift_d;
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_DONE: begin
                cpu_ack = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = (state_q != S_IDLE);
    assign pin_sync  = (state_q == S_ADDR) && (beat_q == '0);
    assign pin_we    = pin_frame & we_q;
    assign dbg_state = state_q;

`ifdef BUS_LANE_PARITY_EN
    assign pin_par  = (pin_oe != '0) ? ^pin_out : 1'b0;
    assign cpu_perr = perr_q;
`else
    // Without parity the error flop has no observer; keep it tied quiet.
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_cpu_bus_lane_bridge.sv
// Table-driven bench for cpu_bus_lane_bridge: lane beats checked from an expected queue,
// latency/rdata checked per vector, plus hand-written reset-abort sequence.
module tb_cpu_bus_lane_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NA = AW / LW;
  localparam int ND = DW / LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_busy;
  logic [LW-1:0] pin_out;
  logic [LW-1:0] pin_oe;
  logic [LW-1:0] pin_in = '0;
  logic          pin_rdy = 1'b1;
  logic          pin_frame;
  logic          pin_sync;
  logic          pin_we;
  logic [2:0]    dbg_state;
`ifdef BUS_LANE_PARITY_EN
  logic          pin_par;
  logic          pin_par_in = 1'b0;
  logic          cpu_perr;
`endif

  cpu_bus_lane_bridge #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in), .pin_rdy(pin_rdy),
    .pin_frame(pin_frame), .pin_sync(pin_sync), .pin_we(pin_we), .dbg_state(dbg_state)
`ifdef BUS_LANE_PARITY_EN
    , .pin_par(pin_par), .pin_par_in(pin_par_in), .cpu_perr(cpu_perr)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every completed driven beat must match the front of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      if (pin_oe != '0) begin
        check("oe_all_ones", 32'(pin_oe), 32'hFF);
        if (pin_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected actual=%0h required=none", pin_out);
          end else begin
            check("beat", 32'(pin_out), 32'(exp_q.pop_front()));
          end
        end else if (exp_q.size() != 0) begin
          check("stall_hold", 32'(pin_out), 32'(exp_q[0]));
        end
      end else begin
        check("undriven_pin_out_zero", 32'(pin_out), 32'h0);
      end
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_val;
    int            stall_start;
    int            stall_len;
    int            exp_lat;
    bit            poke;
    int            bad_par_k;
    bit            exp_perr;
  } vec_t;

  vec_t tbl[9];

  // driver task: one full transaction, lane responder included
  task automatic run_txn(input vec_t v);
    int lat = 0;
    int rb = 0;
    bit seen_turn = 1'b0;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    rd = v.rd_val;
    a = v.addr;
    w = v.wdata;
    cpu_req = 1'b1;
    cpu_we = v.we;
    cpu_addr = a;
    cpu_wdata = w;
    pin_rdy = 1'b1;
    for (int i = 0; i < NA; i++) exp_q.push_back(a[i*LW +: LW]);
    if (v.we) for (int i = 0; i < ND; i++) exp_q.push_back(w[i*LW +: LW]);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we = ~v.we;
    cpu_addr = ~a;
    cpu_wdata = ~w;
    for (int k = 1; k <= 64; k++) begin
      pin_rdy = !(k >= v.stall_start && k < v.stall_start + v.stall_len);
      pin_in = (rb < ND) ? rd[rb*LW +: LW] : '0;
`ifdef BUS_LANE_PARITY_EN
      pin_par_in = (^pin_in) ^ (k == v.bad_par_k);
`endif
      if (v.poke && k == 2) begin
        cpu_req = 1'b1;
        cpu_addr = 32'hDEAD_0000;
      end
      if (v.poke && k == 3) cpu_req = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        check("busy_first", 32'(cpu_busy), 32'h1);
        check("sync_first", 32'(pin_sync), 32'h1);
        check("frame_first", 32'(pin_frame), 32'h1);
        check("pin_we", 32'(pin_we), 32'(v.we));
      end
      if (k == 2 && pin_rdy && v.stall_start != 1) check("sync_second", 32'(pin_sync), 32'h0);
      if (pin_frame && pin_oe == '0) begin
        if (!seen_turn) seen_turn = 1'b1;
        else if (pin_rdy) rb++;
      end
      if (cpu_ack) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("ack_latency", 32'(lat), 32'(v.exp_lat));
    if (lat != 0) begin
      check("rdata", cpu_rdata, v.we ? last_rd : v.rd_val);
      check("busy_at_ack", 32'(cpu_busy), 32'h1);
      check("frame_at_ack", 32'(pin_frame), 32'h0);
      check("turn_seen", 32'(seen_turn), 32'(!v.we));
      check("beats_consumed", 32'(exp_q.size()), 32'h0);
`ifdef BUS_LANE_PARITY_EN
      check("perr", 32'(cpu_perr), 32'(v.exp_perr));
`endif
    end
    if (!v.we) last_rd = v.rd_val;
    exp_q.delete();
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("no_extra_ack", 32'(cpu_ack), 32'h0);
      check("idle_busy", 32'(cpu_busy), 32'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h1234_5678, 32'hCAFE_F00D, 32'h0,         0, 0,  9, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 10, 1'b0, 0, 1'b0};
    tbl[2] = '{1'b1, 32'h1234_5678, 32'hCAFE_F00D, 32'h0,         3, 3, 12, 1'b0, 0, 1'b0};
    tbl[3] = '{1'b0, 32'h89AB_CDEF, 32'h0,         32'hA5A5_5A5A, 7, 2, 12, 1'b0, 0, 1'b0};
    tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         0, 0,  9, 1'b1, 0, 1'b0};
    tbl[5] = '{1'b0, $urandom,      $urandom,      $urandom,      5, 1, 10, 1'b0, 0, 1'b0};
    tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 0, 0, 10, 1'b0, 8, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0246_8ACE, 0, 0, 10, 1'b0, 0, 1'b0};
    tbl[8] = '{1'b1, $urandom,      $urandom,      32'h0,         2, 1, 10, 1'b1, 0, 1'b0};
    tbl[8].stall_len = $urandom_range(1, 3);
    tbl[8].exp_lat = 9 + tbl[8].stall_len;

    rst_n = 1'b0;
    #12;
    check("rst_ack", 32'(cpu_ack), 32'h0);
    check("rst_busy", 32'(cpu_busy), 32'h0);
    check("rst_oe", 32'(pin_oe), 32'h0);
    check("rst_out", 32'(pin_out), 32'h0);
    check("rst_frame", 32'(pin_frame), 32'h0);
    check("rst_sync", 32'(pin_sync), 32'h0);
    check("rst_we", 32'(pin_we), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // reset during WDATA beat 1 aborts the write with no ack
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 32'hA1B2_C3D4;
    cpu_wdata = 32'h5566_7788;
    pin_rdy = 1'b1;
    for (int i = 0; i < NA; i++) exp_q.push_back(cpu_addr[i*LW +: LW]);
    for (int i = 0; i < ND; i++) exp_q.push_back(cpu_wdata[i*LW +: LW]);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int k = 1; k < NA + 2; k++) begin
      @(posedge clk); #1;
    end
    check("pre_abort_state", 32'(dbg_state), 32'h2);
    check("pre_abort_out", 32'(pin_out), 32'h77);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_oe", 32'(pin_oe), 32'h0);
    check("abort_out", 32'(pin_out), 32'h0);
    check("abort_frame", 32'(pin_frame), 32'h0);
    check("abort_busy", 32'(cpu_busy), 32'h0);
    check("abort_ack", 32'(cpu_ack), 32'h0);
    check("abort_rdata", cpu_rdata, 32'h0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(cpu_ack), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;
    run_txn(tbl[0]);
    run_txn(tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
